rcpu_mem_bridge: RTL and testbench
==================================

// Module: rcpu_mem_bridge
// PURPOSE
//   Downstream of the RCPU core's memory port; consumes memAddr/memWrite/memRE/memWE, returns memRead.
//   Converts each 16-bit word access into two 8-bit transactions on an external byte bus (req/ack).
//   Low byte goes first (little-endian).
//   Drives busy, which gates the core's clock-enable so the core holds its request until the access completes.
// PARAMETERS
//   M        16   CPU data width (fixed 2 x 8 bits)
//   N        32   address width, CPU side and bus side
//   TIMEOUT  255  cycles without busAck before a byte transfer is aborted (1..255)
// PORTS
//   clk       in   1  clock, rising edge
//   rst       in   1  reset, asynchronous, active-low
//   memAddr   in   N  CPU word address
//   memWrite  in   M  CPU write data
//   memRE     in   1  CPU read request
//   memWE     in   1  CPU write request
//   memRead   out  M  read data to CPU
//   busy      out  1  CPU must hold its request; clock-enable low while 1
//   busAddr   out  N  byte address
//   busWData  out  8  byte write data
//   busWr     out  1  1 = write, 0 = read; valid while busReq
//   busReq    out  1  transfer request
//   busAck    in   1  target accepts/returns data this cycle
//   busRData  in   8  byte read data; valid when busReq & busAck
//   busErr    out  1  sticky timeout flag
// BEHAVIOUR
//   Reset (async, rst=0): state=IDLE; all outputs 0, including memRead, busy and busErr.
//   FSM states and transitions:
//     IDLE -> LO when memRE|memWE.
//       Latches op, wdata and base = {memAddr[N-2:0],1'b0}; memAddr[N-1] is discarded.
//     LO -> HI when the low byte transfers.
//     HI -> DONE when the high byte transfers.
//     DONE -> IDLE unconditionally.
//   busy is combinational: 1 in LO and HI, and in IDLE when memRE|memWE.
//     busy is 0 in DONE, so the core advances exactly one cycle after the final ack.
//   memWE and memRE together: the write is performed and the read is ignored.
//   Bus handshake:
//     busReq=1 in LO and HI, with busAddr/busWr/busWData stable.
//     A byte transfers on any cycle with busReq & busAck.
//     HI requests in the cycle after the LO transfer, so busReq may stay high across both bytes.
//     LO: busAddr = base, busWData = wdata[7:0].
//     HI: busAddr = base | 1 (no carry), busWData = wdata[15:8].
//   Read data:
//     LO transfer captures busRData into lo.
//     HI transfer loads memRead <= {busRData, lo}; memRead is valid from the DONE cycle.
//     memRead holds until the next completed read; writes never change it.
//   Timeout:
//     8-bit counter cleared on entry to LO and to HI; increments each cycle busReq & !busAck.
//     When the counter reaches TIMEOUT: abort, busReq=0 next cycle, busErr <= 1, goto DONE.
//     If the access was a read, memRead <= 16'hFFFF.
//     busErr clears only on reset.
//     An ack in the same cycle the count reaches TIMEOUT counts as success.
//   Back-to-back accesses: a new request in the IDLE cycle after DONE is accepted.
//     Minimum word access is 4 cycles (IDLE, LO, HI, DONE) with zero-wait acks.
//   Reset mid-transfer: busReq drops immediately (async); a partial write is not undone.
// STRUCTURE
//   Shared constants file:
//     state encodings MB_IDLE=2'd0, MB_LO=2'd1, MB_HI=2'd2, MB_DONE=2'd3
//     MB_RFILL=16'hFFFF
//   Optional sub-module bus_timeout: counter plus compare, inputs clr/inc, output expired.
//   The FSM, data latches and memRead register all live in this module.
// TESTING
//   1. Read, zero-wait: memAddr=0x10, memRE=1, bus returns 0x34 at byte 0x20 and 0x12 at 0x21.
//      -> memRead=0x1234 in DONE; busy high for exactly 3 cycles.
//   2. Write with waits: memAddr=0x8, memWrite=0xBEEF, ack after 2 cycles per byte.
//      -> bus sees 0x10/0xEF then 0x11/0xBE, busWr=1; memRead unchanged.
//   3. Simultaneous memRE=memWE=1 -> exactly one write pair on the bus; memRead unchanged.
//   4. Timeout: never ack, TIMEOUT=4, read.
//      -> busErr=1 after 4 stalled cycles, memRead=0xFFFF, busy released.
//      -> A following good read succeeds with busErr still 1.
//   5. Address wrap: memAddr=0x8000_0001 -> busAddr 0x0000_0002 then 0x0000_0003.
//   6. Reset mid-transfer: rst=0 while in HI.
//      -> busReq, busy, memRead, busErr all 0 without a clock edge; next access starts clean.

Source files
------------

// File: rtl/rcpu_mem_bridge_pkg.sv
// Shared constants for the RCPU memory bridge.
//   MB_*      : FSM state encodings (IDLE, LO byte, HI byte, DONE)
//   MB_RFILL  : read data returned to the core when a byte transfer times out
package rcpu_mem_bridge_pkg;

  localparam logic [1:0] MB_IDLE = 2'd0;
  localparam logic [1:0] MB_LO   = 2'd1;
  localparam logic [1:0] MB_HI   = 2'd2;
  localparam logic [1:0] MB_DONE = 2'd3;

  localparam logic [15:0] MB_RFILL = 16'hFFFF;

endpackage

// File: rtl/rcpu_mem_bridge_timeout.sv
// Stall counter for one byte transfer.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : restart the count (entry to a new byte phase)
//   inc      : a requested cycle passed without an ack
//   expired  : this stalled cycle is the TIMEOUT-th one; abort at the next edge
module bus_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  // The count that would reach TIMEOUT on this cycle is TIMEOUT-1 before it.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 8'd1;
    end
  end

  // An ack on the boundary cycle means inc=0, so it counts as success.
  assign expired = inc && (cnt == LIMIT);

endmodule

// File: rtl/rcpu_mem_bridge.sv
// Bridge from the RCPU 16-bit word memory port to an 8-bit req/ack byte bus.
// Each word access becomes a low-byte then a high-byte transfer (little-endian).
//   clk, rst          : clock, asynchronous active-low reset
//   memAddr/memWrite  : CPU word address / write data
//   memRE/memWE       : CPU read / write request (write wins if both)
//   memRead           : last completed read word (0xFFFF after a timed-out read)
//   busy              : core must hold its request while 1
//   busAddr/busWData  : byte address / write byte, valid while busReq
//   busWr             : 1 = write, 0 = read, valid while busReq
//   busReq/busAck     : byte transfer happens on any cycle with busReq & busAck
//   busRData          : read byte, valid when busReq & busAck
//   busErr            : sticky timeout flag, cleared only by reset
//   fsm_state         : current FSM state (MB_* encoding) for observation
//
// Handshake: busReq is held with busAddr/busWr/busWData stable until a cycle
// where busAck is also 1; that cycle is the transfer. The high byte requests
// in the cycle after the low-byte transfer, so busReq may stay high across both.
module rcpu_mem_bridge
  import rcpu_mem_bridge_pkg::*;
#(
  parameter int M       = 16,
  parameter int N       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] memAddr,
  input  logic [M-1:0] memWrite,
  input  logic         memRE,
  input  logic         memWE,
  output logic [M-1:0] memRead,
  output logic         busy,
  output logic [N-1:0] busAddr,
  output logic [7:0]   busWData,
  output logic         busWr,
  output logic         busReq,
  input  logic         busAck,
  input  logic [7:0]   busRData,
  output logic         busErr,
  output logic [1:0]   fsm_state
);

  logic [1:0]   state;
  logic [1:0]   state_nx;
  logic         op_wr;
  logic [M-1:0] wdata;
  logic [N-1:0] base;
  logic [7:0]   lo;
  logic         req;
  logic         xfer;
  logic         tmo_clr;
  logic         tmo_inc;
  logic         expired;

  assign req     = memRE | memWE;
  assign busReq  = (state == MB_LO) || (state == MB_HI);
  assign xfer    = busReq && busAck;
  assign tmo_clr = ((state == MB_IDLE) && req) || ((state == MB_LO) && xfer);
  assign tmo_inc = busReq && !busAck;

  bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .inc     (tmo_inc),
    .expired (expired)
  );

  always_comb begin
    state_nx = state;
    case (state)
      MB_IDLE: if (req) state_nx = MB_LO;
      MB_LO: begin
        if (xfer)         state_nx = MB_HI;
        else if (expired) state_nx = MB_DONE;
      end
      MB_HI: if (xfer || expired) state_nx = MB_DONE;
      default: state_nx = MB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= MB_IDLE;
      op_wr   <= 1'b0;
      wdata   <= '0;
      base    <= '0;
      lo      <= '0;
      memRead <= '0;
      busErr  <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == MB_IDLE) && req) begin
        op_wr <= memWE;
        wdata <= memWrite;
        // Word address to byte address; the top address bit falls off.
        base  <= memAddr << 1;
      end
      if ((state == MB_LO) && xfer) begin
        lo <= busRData;
      end
      if ((state == MB_HI) && xfer && !op_wr) begin
        memRead <= {busRData, lo};
      end
      if (expired) begin
        busErr <= 1'b1;
        if (!op_wr) memRead <= MB_RFILL;
      end
    end
  end

  always_comb begin
    busAddr  = '0;
    busWData = '0;
    case (state)
      MB_LO: begin
        busAddr  = base;
        busWData = wdata[7:0];
      end
      MB_HI: begin
        // base is always even, so OR-ing bit 0 never carries.
        busAddr  = {base[N-1:1], 1'b1};
        busWData = wdata[15:8];
      end
      default: ;
    endcase
  end

  assign busWr     = busReq && op_wr;
  // Low throughout reset so the core is never stalled by a request it is still presenting.
  assign busy      = rst && (busReq || ((state == MB_IDLE) && req));
  assign fsm_state = state;

endmodule

// File: tb/tb_rcpu_mem_bridge.sv
module tb_rcpu_mem_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] memAddr = '0;
  logic [15:0] memWrite = '0;
  logic        memRE = 1'b0;
  logic        memWE = 1'b0;
  logic [15:0] memRead;
  logic        busy;
  logic [31:0] busAddr;
  logic [7:0]  busWData;
  logic        busWr;
  logic        busReq;
  logic        busAck = 1'b0;
  logic [7:0]  busRData = '0;
  logic        busErr;
  logic [1:0]  fsm_state;

  rcpu_mem_bridge #(.M(16), .N(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .memAddr(memAddr), .memWrite(memWrite),
    .memRE(memRE), .memWE(memWE), .memRead(memRead), .busy(busy),
    .busAddr(busAddr), .busWData(busWData), .busWr(busWr), .busReq(busReq),
    .busAck(busAck), .busRData(busRData), .busErr(busErr), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [40:0] exp_q[$];              // {byte address, write flag, write byte}
  logic [7:0]  bus_mem [logic [31:0]]; // byte-bus target contents
  logic [15:0] exp_read = '0;
  logic        exp_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    if (!bus_mem.exists(a)) bus_mem[a] = 8'($urandom);
    return bus_mem[a];
  endfunction

  // ---------------- driver: one CPU word access ----------------
  // wlo/whi: stall cycles before the bus target acks each byte; >= TMO never acks.
  task automatic run_access(input string tag, input logic [31:0] addr, input logic [15:0] wd,
                            input logic re, input logic we, input int wlo, input int whi);
    logic [31:0] base;
    logic        is_wr;
    logic        timed_out;
    int          exp_busy;
    int          busy_cyc;
    int          phase;
    int          stall;
    int          w;
    logic [40:0] e;
    base      = addr * 2;
    is_wr     = we;
    timed_out = 1'b0;
    exp_busy  = 1;
    exp_q.delete();
    if (wlo >= TMO) begin
      timed_out = 1'b1;
      exp_busy += TMO;
    end else begin
      exp_q.push_back({base, is_wr, wd[7:0]});
      exp_busy += wlo + 1;
      if (whi >= TMO) begin
        timed_out = 1'b1;
        exp_busy += TMO;
      end else begin
        exp_q.push_back({base + 32'd1, is_wr, wd[15:8]});
        exp_busy += whi + 1;
      end
    end
    if (!is_wr) exp_read = timed_out ? 16'hFFFF : {get_byte(base + 32'd1), get_byte(base)};
    if (timed_out) exp_err = 1'b1;

    @(posedge clk);
    #1;
    memAddr = addr; memWrite = wd; memRE = re; memWE = we;
    busy_cyc = 0; phase = 0; stall = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      busAck = 1'b0;
      if (!busy) break;
      busy_cyc++;
      if (busReq) begin
        w = (phase == 0) ? wlo : whi;
        if (stall >= w) begin
          busAck = 1'b1;
          if (exp_q.size() == 0) begin
            chk({tag, "_extra_xfer"}, 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk({tag, "_addr"}, busAddr, e[40:9]);
            chk({tag, "_wr"}, busWr, e[8]);
            if (e[8]) chk({tag, "_wdata"}, busWData, e[7:0]);
          end
          if (busWr) bus_mem[busAddr] = busWData;
          else       busRData = get_byte(busAddr);
          phase++;
          stall = 0;
        end else begin
          stall++;
        end
      end
    end
    chk({tag, "_busy_cycles"}, busy_cyc, exp_busy);
    chk({tag, "_missing_xfer"}, exp_q.size(), 0);
    chk({tag, "_done_req"}, busReq, 1'b0);
    chk({tag, "_memread"}, memRead, exp_read);
    chk({tag, "_buserr"}, busErr, exp_err);
    memRE = 1'b0; memWE = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [15:0] d;
    logic        r, wv;
    int          wl, wh;

    #12;
    chk("rst_memread", memRead, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", busReq, 1'b0);
    chk("rst_err", busErr, 1'b0);
    chk("rst_addr", busAddr, 32'h0);
    chk("rst_state", fsm_state, 2'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1. zero-wait read
    bus_mem[32'h20] = 8'h34;
    bus_mem[32'h21] = 8'h12;
    run_access("t1_read", 32'h10, 16'h0, 1'b1, 1'b0, 0, 0);
    chk("t1_value", memRead, 16'h1234);

    // 2. write with 2 wait cycles per byte
    run_access("t2_write", 32'h8, 16'hBEEF, 1'b0, 1'b1, 2, 2);
    chk("t2_lo_byte", bus_mem[32'h10], 8'hEF);
    chk("t2_hi_byte", bus_mem[32'h11], 8'hBE);

    // 3. read and write together: write only
    run_access("t3_rdwr", 32'h30, 16'hA55A, 1'b1, 1'b1, 1, 0);

    // 4. timeout on a read, then a good read with busErr still set
    run_access("t4_tmo", 32'h40, 16'h0, 1'b1, 1'b0, TMO + 5, 0);
    run_access("t4_after", 32'h41, 16'h0, 1'b1, 1'b0, 0, 1);
    // boundary: ack on the last allowed cycle succeeds
    run_access("t4_edge", 32'h42, 16'h0, 1'b1, 1'b0, TMO - 1, TMO - 1);
    // timeout in the high byte of a write
    run_access("t4_hi_tmo", 32'h43, 16'h1357, 1'b0, 1'b1, 0, TMO);

    // 5. address wrap
    run_access("t5_wrap", 32'h8000_0001, 16'hC0DE, 1'b0, 1'b1, 0, 0);
    chk("t5_lo", bus_mem[32'h2], 8'hDE);
    chk("t5_hi", bus_mem[32'h3], 8'hC0);

    // 6. reset while the high byte is requested
    @(posedge clk);
    #1;
    memAddr = 32'h50; memRE = 1'b1;
    @(negedge clk);                 // IDLE with request
    @(negedge clk);                 // LO
    busAck = 1'b1; busRData = 8'h77;
    @(negedge clk);                 // HI
    busAck = 1'b0;
    chk("t6_in_hi_addr", busAddr, 32'hA1);
    #2 rst = 1'b0;
    #1;
    chk("t6_req", busReq, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_memread", memRead, 16'h0);
    chk("t6_err", busErr, 1'b0);
    memRE = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_read = '0;
    exp_err  = 1'b0;
    run_access("t6_clean", 32'h60, 16'h0, 1'b1, 1'b0, 0, 0);

    // random accesses
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      d  = 16'($urandom);
      r  = 1'($urandom_range(0, 1));
      wv = 1'($urandom_range(0, 1));
      if (!r && !wv) r = 1'b1;
      wl = ($urandom_range(0, 9) < 8) ? $urandom_range(0, TMO - 1) : $urandom_range(TMO, TMO + 2);
      wh = ($urandom_range(0, 9) < 8) ? $urandom_range(0, TMO - 1) : $urandom_range(TMO, TMO + 2);
      run_access("rnd", a, d, r, wv, wl, wh);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
